// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encodings,
// default wait timeout and a saturating counter helper.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_NPU_WAIT = 2'd2,
      ST_FLUSH    = 2'd3
   } state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

   // 8-bit increment that sticks at all-ones
   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      if (val == 8'hFF) return val;
      else              return val + 8'd1;
   endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// Load-use hazard detection: the decoder reads a register that a load
// sitting in the instruction buffer has not yet written.
module pipe_hazard_unit (
   input  logic       dec_valid_i,
   input  logic [4:0] dec_rs1_i,
   input  logic [4:0] dec_rs2_i,
   input  logic       ex_reg_we_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_load_i,
   output logic       hazard_o
);

   logic rd_match;

   // r0 is hard-wired zero, so a load to r0 never creates a dependency
   always_comb begin
      rd_match = (ex_rd_i == dec_rs1_i) || (ex_rd_i == dec_rs2_i);
      hazard_o = dec_valid_i && ex_load_i && ex_reg_we_i &&
                 (ex_rd_i != 5'd0) && rd_match;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: steers the instruction buffer (capture / bubble /
// hold), stalls fetch on load-use hazards and while RAM or NPU operations
// are outstanding, and inserts two bubbles behind a taken branch.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       dec_valid_i,
   input  logic [4:0] dec_rs1_i,
   input  logic [4:0] dec_rs2_i,
   input  logic       dec_mem_i,
   input  logic       dec_npu_i,
   input  logic       ex_reg_we_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_load_i,
   input  logic       mem_ready_i,
   input  logic       npu_done_i,
   input  logic       branch_taken_i,
   output logic       buf_en_o,
   output logic       buf_flush_o,
   output logic       pc_stall_o,
   output logic       npu_start_o,
   output logic [1:0] state_o,
   output logic [7:0] stall_cnt_o,
   output logic       err_o
);

   localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic [7:0] stall_cnt_q, stall_cnt_d;
   logic       err_q, err_d;
   logic       hazard;
   logic       wait_expired;

   pipe_hazard_unit u_hazard (
      .dec_valid_i (dec_valid_i),
      .dec_rs1_i   (dec_rs1_i),
      .dec_rs2_i   (dec_rs2_i),
      .ex_reg_we_i (ex_reg_we_i),
      .ex_rd_i     (ex_rd_i),
      .ex_load_i   (ex_load_i),
      .hazard_o    (hazard)
   );

   // Next state and buffer/fetch control; outputs are combinational so the
   // buffer acts on the same edge the decision is made
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      err_d       = err_q;
      buf_en_o    = 1'b0;
      buf_flush_o = 1'b0;
      pc_stall_o  = 1'b0;
      npu_start_o = 1'b0;
      // the current wait cycle is counted, so the TIMEOUT-th cycle expires
      wait_expired = ({1'b0, wait_cnt_q} + 9'd1) == TIMEOUT_W;

      unique case (state_q)
         ST_RUN: begin
            if (branch_taken_i) begin
               buf_flush_o = 1'b1;
               state_d     = ST_FLUSH;
            end else if (hazard) begin
               buf_flush_o = 1'b1;
               pc_stall_o  = 1'b1;
            end else if (dec_valid_i && dec_npu_i) begin
               buf_en_o    = 1'b1;
               npu_start_o = 1'b1;
               wait_cnt_d  = 8'd0;
               state_d     = ST_NPU_WAIT;
            end else if (dec_valid_i && dec_mem_i) begin
               buf_en_o   = 1'b1;
               wait_cnt_d = 8'd0;
               state_d    = ST_MEM_WAIT;
            end else if (dec_valid_i) begin
               buf_en_o = 1'b1;
            end else begin
               buf_flush_o = 1'b1;
            end
         end
         ST_MEM_WAIT, ST_NPU_WAIT: begin
            // buffer holds; branches are ignored while waiting
            pc_stall_o = 1'b1;
            if ((state_q == ST_MEM_WAIT) ? mem_ready_i : npu_done_i) begin
               state_d = ST_RUN;
            end else if (wait_expired) begin
               err_d   = 1'b1;
               state_d = ST_RUN;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_FLUSH: begin
            // second bubble behind a taken branch; fetch already redirected
            buf_flush_o = 1'b1;
            state_d     = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      stall_cnt_d = pc_stall_o ? sat_inc8(stall_cnt_q) : stall_cnt_q;

      if (rst_i) begin
         buf_en_o    = 1'b0;
         buf_flush_o = 1'b1;
         pc_stall_o  = 1'b1;
         npu_start_o = 1'b0;
      end
   end

   // State, wait counter, stall statistics and sticky error register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= 8'd0;
         stall_cnt_q <= 8'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   assign state_o     = state_q;
   assign stall_cnt_o = stall_cnt_q;
   assign err_o       = err_q;

endmodule
